// File: rtl/csc_pkg.sv
// Shared definitions for the colour-space output scheduler.
package csc_pkg;

    localparam int unsigned STREAM_W = 24;
    localparam int unsigned BUS_W    = STREAM_W + 3;

    localparam logic [1:0] MODE_RGB   = 2'd0;
    localparam logic [1:0] MODE_HSV   = 2'd1;
    localparam logic [1:0] MODE_YCBCR = 2'd2;
    localparam logic [1:0] MODE_HSI   = 2'd3;

    typedef enum logic {
        MUTE,
        RUN
    } state_e;

    typedef struct packed {
        logic                hs;
        logic                vs;
        logic                de;
        logic [STREAM_W-1:0] data;
    } stream_t;

endpackage

// File: rtl/csc_delay_line.sv
// Fixed-depth register pipeline used to align the raw RGB stream with the converter outputs.
module csc_delay_line #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        assign q_o = d_i;
    end else begin : g_pipe
        logic [WIDTH-1:0] pipe_q [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign q_o = pipe_q[DEPTH-1];
    end

endmodule

// File: rtl/csc_out_sched.sv
// Frame-synchronous selector of one of four colour-space streams towards the VGA port.
// Mode switches land on frame boundaries and the first partial frame of the new stream is muted.
module csc_out_sched
    import csc_pkg::*;
#(
    parameter int unsigned DEF_MODE    = 0,
    parameter int unsigned RGB_LAT     = 3,
    parameter int unsigned AUTO_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode_req_valid,
    input  logic [1:0]  mode_req,
    output logic        mode_req_ready,
    input  logic        auto_en,
    input  logic        RGB_hsync,
    input  logic        RGB_vsync,
    input  logic        RGB_de,
    input  logic [23:0] RGB_data,
    input  logic        HSV_hsync,
    input  logic        HSV_vsync,
    input  logic        HSV_de,
    input  logic [23:0] HSV_data,
    input  logic        YCbCr_hsync,
    input  logic        YCbCr_vsync,
    input  logic        YCbCr_de,
    input  logic [23:0] YCbCr_data,
    input  logic        HSI_hsync,
    input  logic        HSI_vsync,
    input  logic        HSI_de,
    input  logic [23:0] HSI_data,
    output logic        VGA_hsync,
    output logic        VGA_vsync,
    output logic        VGA_de,
    output logic [23:0] VGA_data,
    output logic [1:0]  cur_mode,
    output logic [15:0] frame_cnt
);

    localparam logic [15:0] AUTO_LAST = 16'(AUTO_FRAMES - 1);

    stream_t rgb_in, rgb_dly, hsv_s, ycc_s, hsi_s, sel;

    assign rgb_in = '{hs: RGB_hsync, vs: RGB_vsync, de: RGB_de, data: RGB_data};
    assign hsv_s  = '{hs: HSV_hsync, vs: HSV_vsync, de: HSV_de, data: HSV_data};
    assign ycc_s  = '{hs: YCbCr_hsync, vs: YCbCr_vsync, de: YCbCr_de, data: YCbCr_data};
    assign hsi_s  = '{hs: HSI_hsync, vs: HSI_vsync, de: HSI_de, data: HSI_data};

    csc_delay_line #(
        .DEPTH (RGB_LAT),
        .WIDTH (BUS_W)
    ) u_rgb_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rgb_in),
        .q_o   (rgb_dly)
    );

    state_e      state_q, state_d;
    logic [1:0]  cur_mode_q, cur_mode_d;
    logic        pend_vld_q, pend_vld_d;
    logic [1:0]  pend_mode_q, pend_mode_d;
    logic [15:0] auto_cnt_q, auto_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        vs_prev_q;
    stream_t     out_q, out_d;
    logic        vs_rise;
    logic        req_acc;

    always_comb begin
        case (cur_mode_q)
            MODE_RGB:   sel = rgb_dly;
            MODE_HSV:   sel = hsv_s;
            MODE_YCBCR: sel = ycc_s;
            MODE_HSI:   sel = hsi_s;
            default:    sel = rgb_dly;
        endcase
    end

    assign vs_rise        = sel.vs & ~vs_prev_q;
    assign mode_req_ready = (state_q == RUN) && !pend_vld_q;
    assign req_acc        = mode_req_valid & mode_req_ready;

    always_comb begin
        state_d     = state_q;
        cur_mode_d  = cur_mode_q;
        pend_vld_d  = pend_vld_q;
        pend_mode_d = pend_mode_q;
        auto_cnt_d  = auto_en ? auto_cnt_q : '0;
        frame_cnt_d = frame_cnt_q;
        out_d       = '0;

        // A request for the mode already on screen is consumed without effect.
        if (req_acc && (mode_req != cur_mode_q)) begin
            pend_vld_d  = 1'b1;
            pend_mode_d = mode_req;
        end

        case (state_q)
            MUTE: begin
                if (vs_rise) begin
                    state_d = RUN;
                    out_d   = sel;
                end
            end
            RUN: begin
                out_d = sel;
                if (vs_rise) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    if (auto_en) begin
                        auto_cnt_d = auto_cnt_q + 16'd1;
                    end
                    // Manual switch has priority over the auto tick on the same edge.
                    if (pend_vld_q) begin
                        cur_mode_d = pend_mode_q;
                        pend_vld_d = 1'b0;
                        auto_cnt_d = '0;
                        state_d    = MUTE;
                        out_d      = '0;
                    end else if (auto_en && (auto_cnt_q == AUTO_LAST)) begin
                        cur_mode_d = cur_mode_q + 2'd1;
                        auto_cnt_d = '0;
                        state_d    = MUTE;
                        out_d      = '0;
                    end
                end
            end
            default: state_d = MUTE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MUTE;
            cur_mode_q  <= 2'(DEF_MODE);
            pend_vld_q  <= 1'b0;
            pend_mode_q <= '0;
            auto_cnt_q  <= '0;
            frame_cnt_q <= '0;
            vs_prev_q   <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            cur_mode_q  <= cur_mode_d;
            pend_vld_q  <= pend_vld_d;
            pend_mode_q <= pend_mode_d;
            auto_cnt_q  <= auto_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            vs_prev_q   <= sel.vs;
            out_q       <= out_d;
        end
    end

    assign VGA_hsync = out_q.hs;
    assign VGA_vsync = out_q.vs;
    assign VGA_de    = out_q.de;
    assign VGA_data  = out_q.data;
    assign cur_mode  = cur_mode_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_csc_out_sched.sv
// Directed bench for csc_out_sched: stimulus pushes expected VGA pixels, a negedge monitor pops them.
module tb_csc_out_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode_req_valid;
    logic [1:0]  mode_req;
    logic        mode_req_ready;
    logic        auto_en;
    logic [3:0]  hs, vs, de;
    logic [23:0] dat [4];
    logic        VGA_hsync, VGA_vsync, VGA_de;
    logic [23:0] VGA_data;
    logic [1:0]  cur_mode;
    logic [15:0] frame_cnt;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          pix_id = 0;
    logic [23:0] exp_q [$];
    logic [23:0] mon_exp;

    always #5 clk = ~clk;

    csc_out_sched #(
        .DEF_MODE    (1),
        .RGB_LAT     (3),
        .AUTO_FRAMES (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mode_req_valid (mode_req_valid),
        .mode_req       (mode_req),
        .mode_req_ready (mode_req_ready),
        .auto_en        (auto_en),
        .RGB_hsync      (hs[0]),
        .RGB_vsync      (vs[0]),
        .RGB_de         (de[0]),
        .RGB_data       (dat[0]),
        .HSV_hsync      (hs[1]),
        .HSV_vsync      (vs[1]),
        .HSV_de         (de[1]),
        .HSV_data       (dat[1]),
        .YCbCr_hsync    (hs[2]),
        .YCbCr_vsync    (vs[2]),
        .YCbCr_de       (de[2]),
        .YCbCr_data     (dat[2]),
        .HSI_hsync      (hs[3]),
        .HSI_vsync      (vs[3]),
        .HSI_de         (de[3]),
        .HSI_data       (dat[3]),
        .VGA_hsync      (VGA_hsync),
        .VGA_vsync      (VGA_vsync),
        .VGA_de         (VGA_de),
        .VGA_data       (VGA_data),
        .cur_mode       (cur_mode),
        .frame_cnt      (frame_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Drive one cycle on stream s; all other streams idle.
    task automatic step(input int s, input logic h, input logic v, input logic e,
                        input logic [23:0] d);
        @(posedge clk);
        #1;
        hs = '0;
        vs = '0;
        de = '0;
        for (int i = 0; i < 4; i++) dat[i] = '0;
        hs[s]  = h;
        vs[s]  = v;
        de[s]  = e;
        dat[s] = d;
    endtask

    task automatic frame(input int s, input int npix, input bit show);
        logic [23:0] d;
        step(s, 1'b0, 1'b1, 1'b0, 24'h0);
        step(s, 1'b0, 1'b1, 1'b0, 24'h0);
        step(s, 1'b0, 1'b0, 1'b0, 24'h0);
        for (int i = 0; i < npix; i++) begin
            d = {4'(s), 20'(pix_id)};
            pix_id++;
            step(s, 1'b1, 1'b0, 1'b1, d);
            if (show) exp_q.push_back(d);
        end
        repeat (6) step(s, 1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic request(input logic [1:0] m);
        int n;
        @(posedge clk);
        #1;
        mode_req_valid = 1'b1;
        mode_req       = m;
        n = 0;
        while (!mode_req_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("req_ready_seen", 32'(mode_req_ready), 32'd1);
        @(posedge clk);
        #1;
        mode_req_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && VGA_de) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL vga_unexpected: got data %06h, required no output", VGA_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (VGA_data === mon_exp) n_pass++;
                else $display("FAIL vga_data: got %06h, required %06h", VGA_data, mon_exp);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n          = 1'b0;
        mode_req_valid = 1'b0;
        mode_req       = '0;
        auto_en        = 1'b0;
        hs             = '0;
        vs             = '0;
        de             = '0;
        for (int i = 0; i < 4; i++) dat[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_vga", {VGA_hsync, VGA_vsync, VGA_de, 5'd0, VGA_data}, 32'h0);
        chk("rst_cur_mode", 32'(cur_mode), 32'd1);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_ready", 32'(mode_req_ready), 32'd0);
        rst_n = 1'b1;

        // HSV frame lifts MUTE, then a counted HSV frame.
        frame(1, 4, 1'b1);
        chk("run_ready", 32'(mode_req_ready), 32'd1);
        chk("first_frame_cnt", 32'(frame_cnt), 32'd0);
        frame(1, 4, 1'b1);
        chk("hsv_frame_cnt", 32'(frame_cnt), 32'd1);

        // Manual switch to YCbCr.
        request(2'd2);
        chk("ready_after_accept", 32'(mode_req_ready), 32'd0);
        chk("mode_before_edge", 32'(cur_mode), 32'd1);
        frame(1, 4, 1'b0);
        chk("switch_mode", 32'(cur_mode), 32'd2);
        chk("switch_frame_cnt", 32'(frame_cnt), 32'd2);
        frame(2, 4, 1'b1);
        chk("ycc_unmute_cnt", 32'(frame_cnt), 32'd2);

        // Same-mode request is swallowed; next frame is not muted.
        request(2'd2);
        chk("same_mode_ready", 32'(mode_req_ready), 32'd1);
        frame(2, 4, 1'b1);
        chk("same_mode_mode", 32'(cur_mode), 32'd2);
        chk("same_mode_cnt", 32'(frame_cnt), 32'd3);

        // Switch to HSI, then auto-advance after two RUN frame edges.
        request(2'd3);
        frame(2, 4, 1'b0);
        frame(3, 4, 1'b1);
        chk("hsi_mode", 32'(cur_mode), 32'd3);
        auto_en = 1'b1;
        frame(3, 4, 1'b1);
        chk("auto_one_edge", 32'(cur_mode), 32'd3);
        frame(3, 4, 1'b0);
        chk("auto_wrap_mode", 32'(cur_mode), 32'd0);
        chk("auto_frame_cnt", 32'(frame_cnt), 32'd6);

        // RGB passthrough: delay line plus output register.
        frame(0, 4, 1'b1);
        step(0, 1'b1, 1'b0, 1'b1, 24'h12AB34);
        exp_q.push_back(24'h12AB34);
        step(0, 1'b0, 1'b0, 1'b0, 24'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rgb_lat_early_de", 32'(VGA_de), 32'd0);
        @(posedge clk);
        #1;
        chk("rgb_lat_data", {7'd0, VGA_de, VGA_data}, 32'h0112AB34);

        // Manual request lands on the auto-tick edge: manual wins.
        frame(0, 4, 1'b1);
        chk("pre_tick_cnt", 32'(frame_cnt), 32'd7);
        request(2'd2);
        frame(0, 4, 1'b0);
        chk("manual_beats_auto", 32'(cur_mode), 32'd2);
        chk("manual_tick_cnt", 32'(frame_cnt), 32'd8);
        frame(2, 4, 1'b1);
        frame(2, 4, 1'b1);
        chk("auto_cnt_cleared", 32'(cur_mode), 32'd2);
        chk("post_tick_cnt", 32'(frame_cnt), 32'd9);
        auto_en = 1'b0;

        // Frame counter wrap.
        @(posedge clk);
        #1;
        force dut.frame_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.frame_cnt_q;
        frame(2, 4, 1'b1);
        chk("cnt_ffff", 32'(frame_cnt), 32'hFFFF);
        frame(2, 4, 1'b1);
        chk("cnt_wrap", 32'(frame_cnt), 32'h0);

        // Reset asserted mid-line.
        step(2, 1'b0, 1'b1, 1'b0, 24'h0);
        step(2, 1'b0, 1'b0, 1'b0, 24'h0);
        step(2, 1'b1, 1'b0, 1'b1, 24'hC0FFEE);
        @(posedge clk);
        #1;
        chk("midline_pixel", {7'd0, VGA_de, VGA_data}, 32'h01C0FFEE);
        rst_n = 1'b0;
        #1;
        chk("midrst_vga", {VGA_hsync, VGA_vsync, VGA_de, 5'd0, VGA_data}, 32'h0);
        chk("midrst_mode", 32'(cur_mode), 32'd1);
        chk("midrst_cnt", 32'(frame_cnt), 32'd0);
        chk("midrst_ready", 32'(mode_req_ready), 32'd0);
        step(2, 1'b0, 1'b0, 1'b0, 24'h0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Still muted until an HSV vsync arrives.
        for (int i = 0; i < 3; i++) step(1, 1'b1, 1'b0, 1'b1, 24'hBAD000 + 24'(i));
        step(1, 1'b0, 1'b0, 1'b0, 24'h0);
        chk("post_rst_ready", 32'(mode_req_ready), 32'd0);
        frame(1, 4, 1'b1);
        chk("recover_ready", 32'(mode_req_ready), 32'd1);

        repeat (4) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
